// File: rtl/cpu_pkg.sv
// Shared machine-mode CSR definitions for the 5-stage core.
// Addresses, CSR op encodings, bit indices and trap FSM states.
package cpu_pkg;

  typedef enum logic [11:0] {
    CSR_MSTATUS   = 12'h300,
    CSR_MIE       = 12'h304,
    CSR_MTVEC     = 12'h305,
    CSR_MEPC      = 12'h341,
    CSR_MIP       = 12'h344,
    CSR_MCYCLE    = 12'hB00,
    CSR_MINSTRET  = 12'hB02,
    CSR_MCYCLEH   = 12'hB80,
    CSR_MINSTRETH = 12'hB82,
    CSR_CYCLE     = 12'hC00,
    CSR_INSTRET   = 12'hC02,
    CSR_CYCLEH    = 12'hC80,
    CSR_INSTRETH  = 12'hC82
  } csr_addr_e;

  typedef enum logic [3:0] {
    OP_RW         = 4'd0,
    OP_RS         = 4'd1,
    OP_RC         = 4'd2,
    OP_RWI        = 4'd3,
    OP_RSI        = 4'd4,
    OP_RCI        = 4'd5,
    OP_RDCYCLE    = 4'd6,
    OP_RDINSTRET  = 4'd7,
    OP_RDCYCLEH   = 4'd8,
    OP_RDINSTRETH = 4'd9
  } csr_op_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_SLEEP = 1'b1
  } trap_state_e;

  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MEIE     = 11;
  localparam int MIE_MTIE     = 7;

endpackage

// File: rtl/csr_counter64.sv
// 64-bit free-running counter with independent 32-bit half writes.
// A half write overrides that half of the incremented value.
module csr_counter64 (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_inc,
  input  logic        i_we_lo,
  input  logic        i_we_hi,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_cnt
);

  logic [63:0] r_cnt;
  logic [63:0] w_next;

  always_comb begin
    w_next = r_cnt + {63'd0, i_inc};
    if (i_we_lo) w_next[31:0]  = i_wdata;
    if (i_we_hi) w_next[63:32] = i_wdata;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_cnt <= '0;
    else       r_cnt <= w_next;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/csr_trap_controller.sv
// Machine-mode CSR file and RUN/SLEEP trap sequencer beside EX.
// Redirect and read data are combinational from EX inputs.
module csr_trap_controller
  import cpu_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0001_0000,
  parameter int          XLEN      = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ex_valid,
  input  logic            ex_stall,
  input  logic            ex_csr_inst,
  input  logic            ex_csr_we,
  input  logic [3:0]      ex_csr_ctrl,
  input  logic [11:0]     ex_csr_addr,
  input  logic [XLEN-1:0] ex_rs1_data,
  input  logic [4:0]      ex_zimm,
  input  logic            ex_mret,
  input  logic            ex_wfi,
  input  logic [XLEN-1:0] ex_pc,
  input  logic            wb_retire,
  input  logic            irq_ext,
  input  logic            irq_timer,
  output logic [XLEN-1:0] csr_rdata,
  output logic            trap_redirect,
  output logic [XLEN-1:0] trap_pc,
  output logic            wfi_halt
);

  trap_state_e     r_state;
  logic            r_mie_b;
  logic            r_mpie;
  logic            r_meie;
  logic            r_mtie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_wake_pc;

  logic [63:0]     w_cyc;
  logic [63:0]     w_ins;
  logic [XLEN-1:0] w_mstatus;
  logic [XLEN-1:0] w_mie;
  logic [XLEN-1:0] w_mip;
  logic [XLEN-1:0] w_old;
  logic [XLEN-1:0] w_src;
  logic [XLEN-1:0] w_wdata;
  logic            w_wen_op;
  csr_op_e         w_op;
  csr_addr_e       w_addr;
  logic            w_commit;
  logic            w_pend;
  logic            w_take_irq;
  logic            w_csr_wr;
  logic            w_mret;
  logic            w_wfi;
  logic            w_wake;
  logic            w_wake_trap;

  assign w_op   = csr_op_e'(ex_csr_ctrl);
  assign w_addr = csr_addr_e'(ex_csr_addr);

  assign w_mstatus = {19'd0, 2'b11, 3'd0, r_mpie, 3'd0, r_mie_b, 3'd0};
  assign w_mie     = {20'd0, r_meie, 3'd0, r_mtie, 7'd0};
  assign w_mip     = {20'd0, irq_ext, 3'd0, irq_timer, 7'd0};

  always_comb begin
    w_old = '0;
    case (w_addr)
      CSR_MSTATUS:              w_old = w_mstatus;
      CSR_MIE:                  w_old = w_mie;
      CSR_MTVEC:                w_old = r_mtvec;
      CSR_MEPC:                 w_old = r_mepc;
      CSR_MIP:                  w_old = w_mip;
      CSR_MCYCLE, CSR_CYCLE:    w_old = w_cyc[31:0];
      CSR_MCYCLEH, CSR_CYCLEH:  w_old = w_cyc[63:32];
      CSR_MINSTRET, CSR_INSTRET:   w_old = w_ins[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: w_old = w_ins[63:32];
      default:                  w_old = '0;
    endcase
    // Counter pseudo-ops ignore the address field
    case (w_op)
      OP_RDCYCLE:    w_old = w_cyc[31:0];
      OP_RDINSTRET:  w_old = w_ins[31:0];
      OP_RDCYCLEH:   w_old = w_cyc[63:32];
      OP_RDINSTRETH: w_old = w_ins[63:32];
      default:       ;
    endcase
  end

  assign csr_rdata = (ex_valid & ex_csr_inst) ? w_old : '0;

  always_comb begin
    w_src    = ex_rs1_data;
    w_wdata  = '0;
    w_wen_op = 1'b0;
    if (w_op == OP_RWI || w_op == OP_RSI || w_op == OP_RCI)
      w_src = {{(XLEN-5){1'b0}}, ex_zimm};
    case (w_op)
      OP_RW, OP_RWI: begin
        w_wdata  = w_src;
        w_wen_op = 1'b1;
      end
      OP_RS, OP_RSI: begin
        w_wdata  = w_old | w_src;
        w_wen_op = |w_src;
      end
      OP_RC, OP_RCI: begin
        w_wdata  = w_old & ~w_src;
        w_wen_op = |w_src;
      end
      default: ;
    endcase
  end

  assign w_commit    = ex_valid & ~ex_stall & (r_state == ST_RUN);
  assign w_pend      = |(w_mip & w_mie);
  assign w_take_irq  = w_commit & r_mie_b & w_pend;
  assign w_csr_wr    = w_commit & ~w_take_irq & ex_csr_inst
                     & ex_csr_we & w_wen_op;
  assign w_mret      = w_commit & ~w_take_irq & ex_mret;
  assign w_wfi       = w_commit & ~w_take_irq & ex_wfi & ~w_pend;
  assign w_wake      = (r_state == ST_SLEEP) & w_pend;
  assign w_wake_trap = w_wake & r_mie_b;

  assign trap_redirect = w_take_irq | w_mret | w_wake;
  assign wfi_halt      = (r_state == ST_SLEEP);

  always_comb begin
    trap_pc = '0;
    if (w_take_irq || w_wake_trap) trap_pc = r_mtvec;
    else if (w_mret)               trap_pc = r_mepc;
    else if (w_wake)               trap_pc = r_wake_pc;
  end

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rstn    (rstn),
    .i_inc   (1'b1),
    .i_we_lo (w_csr_wr & (w_addr == CSR_MCYCLE)),
    .i_we_hi (w_csr_wr & (w_addr == CSR_MCYCLEH)),
    .i_wdata (w_wdata),
    .o_cnt   (w_cyc)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rstn    (rstn),
    .i_inc   (wb_retire),
    .i_we_lo (w_csr_wr & (w_addr == CSR_MINSTRET)),
    .i_we_hi (w_csr_wr & (w_addr == CSR_MINSTRETH)),
    .i_wdata (w_wdata),
    .o_cnt   (w_ins)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= ST_RUN;
      r_mie_b   <= 1'b0;
      r_mpie    <= 1'b0;
      r_meie    <= 1'b0;
      r_mtie    <= 1'b0;
      r_mtvec   <= MTVEC_RST;
      r_mepc    <= '0;
      r_wake_pc <= '0;
    end else if (w_take_irq) begin
      r_mepc  <= {ex_pc[XLEN-1:2], 2'b00};
      r_mpie  <= r_mie_b;
      r_mie_b <= 1'b0;
    end else if (w_wake_trap) begin
      r_mepc  <= r_wake_pc;
      r_mpie  <= r_mie_b;
      r_mie_b <= 1'b0;
      r_state <= ST_RUN;
    end else if (w_wake) begin
      r_state <= ST_RUN;
    end else if (w_mret) begin
      r_mie_b <= r_mpie;
      r_mpie  <= 1'b1;
    end else if (w_wfi) begin
      r_state   <= ST_SLEEP;
      r_wake_pc <= ex_pc + 32'd4;
    end else if (w_csr_wr) begin
      case (w_addr)
        CSR_MSTATUS: begin
          r_mie_b <= w_wdata[MSTATUS_MIE];
          r_mpie  <= w_wdata[MSTATUS_MPIE];
        end
        CSR_MIE: begin
          r_meie <= w_wdata[MIE_MEIE];
          r_mtie <= w_wdata[MIE_MTIE];
        end
        CSR_MTVEC: r_mtvec <= {w_wdata[XLEN-1:2], 2'b00};
        CSR_MEPC:  r_mepc  <= {w_wdata[XLEN-1:2], 2'b00};
        default:   ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap_controller.sv
// Directed bench for csr_trap_controller.
// Inputs change on negedge; outputs checked 1ns later.
module tb_csr_trap_controller;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_valid;
  logic        ex_stall;
  logic        ex_csr_inst;
  logic        ex_csr_we;
  logic [3:0]  ex_csr_ctrl;
  logic [11:0] ex_csr_addr;
  logic [31:0] ex_rs1_data;
  logic [4:0]  ex_zimm;
  logic        ex_mret;
  logic        ex_wfi;
  logic [31:0] ex_pc;
  logic        wb_retire;
  logic        irq_ext;
  logic        irq_timer;
  logic [31:0] csr_rdata;
  logic        trap_redirect;
  logic [31:0] trap_pc;
  logic        wfi_halt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  csr_trap_controller dut (
    .clk           (clk),
    .rstn          (rstn),
    .ex_valid      (ex_valid),
    .ex_stall      (ex_stall),
    .ex_csr_inst   (ex_csr_inst),
    .ex_csr_we     (ex_csr_we),
    .ex_csr_ctrl   (ex_csr_ctrl),
    .ex_csr_addr   (ex_csr_addr),
    .ex_rs1_data   (ex_rs1_data),
    .ex_zimm       (ex_zimm),
    .ex_mret       (ex_mret),
    .ex_wfi        (ex_wfi),
    .ex_pc         (ex_pc),
    .wb_retire     (wb_retire),
    .irq_ext       (irq_ext),
    .irq_timer     (irq_timer),
    .csr_rdata     (csr_rdata),
    .trap_redirect (trap_redirect),
    .trap_pc       (trap_pc),
    .wfi_halt      (wfi_halt)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ex_valid    = 1'b0;
    ex_stall    = 1'b0;
    ex_csr_inst = 1'b0;
    ex_csr_we   = 1'b0;
    ex_csr_ctrl = 4'd0;
    ex_csr_addr = 12'd0;
    ex_rs1_data = 32'd0;
    ex_zimm     = 5'd0;
    ex_mret     = 1'b0;
    ex_wfi      = 1'b0;
    ex_pc       = 32'd0;
  endtask

  task automatic drive_wr(input logic [3:0] c, input logic [11:0] a,
                          input logic [31:0] d, input logic [4:0] z);
    ex_valid    = 1'b1;
    ex_csr_inst = 1'b1;
    ex_csr_we   = 1'b1;
    ex_csr_ctrl = c;
    ex_csr_addr = a;
    ex_rs1_data = d;
    ex_zimm     = z;
  endtask

  task automatic rd(input string tag, input logic [3:0] c,
                    input logic [11:0] a, input logic [31:0] exp);
    @(negedge clk);
    ex_valid    = 1'b1;
    ex_csr_inst = 1'b1;
    ex_csr_ctrl = c;
    ex_csr_addr = a;
    #1 chk(tag, csr_rdata, exp);
    idle();
  endtask

  task automatic wr(input logic [3:0] c, input logic [11:0] a,
                    input logic [31:0] d, input logic [4:0] z);
    @(negedge clk);
    drive_wr(c, a, d, z);
    @(posedge clk);
    #1 idle();
  endtask

  task automatic wrc(input string tag, input logic [3:0] c,
                     input logic [11:0] a, input logic [31:0] d,
                     input logic [4:0] z, input logic [31:0] old);
    @(negedge clk);
    drive_wr(c, a, d, z);
    #1 chk(tag, csr_rdata, old);
    @(posedge clk);
    #1 idle();
  endtask

  task automatic do_wfi(input logic [31:0] pc);
    @(negedge clk);
    ex_valid = 1'b1;
    ex_wfi   = 1'b1;
    ex_pc    = pc;
    #1 chk("wfi_no_redirect", {31'd0, trap_redirect}, 32'd0);
    @(posedge clk);
    #1 idle();
    @(negedge clk);
    #1 chk("wfi_halt_set", {31'd0, wfi_halt}, 32'd1);
  endtask

  initial begin
    rstn      = 1'b0;
    wb_retire = 1'b0;
    irq_ext   = 1'b0;
    irq_timer = 1'b0;
    idle();
    #1;
    chk("rst_rdata", csr_rdata, 32'd0);
    chk("rst_redirect", {31'd0, trap_redirect}, 32'd0);
    chk("rst_trap_pc", trap_pc, 32'd0);
    chk("rst_wfi_halt", {31'd0, wfi_halt}, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (10) @(posedge clk);

    rd("mcycle_10", 4'd1, 12'hB00, 32'd10);
    rd("mcycleh_0", 4'd1, 12'hB80, 32'd0);
    rd("cycle_alias", 4'd1, 12'hC00, 32'd12);
    rd("mstatus_rst", 4'd1, 12'h300, 32'h0000_1800);
    rd("mtvec_rst", 4'd1, 12'h305, 32'h0001_0000);
    rd("minstret_rst", 4'd1, 12'hB02, 32'd0);
    rd("unknown_addr", 4'd1, 12'h123, 32'd0);

    wrc("mtvec_old", 4'd0, 12'h305, 32'h0000_2003, 5'd0, 32'h0001_0000);
    rd("mtvec_wr", 4'd1, 12'h305, 32'h0000_2000);
    wr(4'd2, 12'h305, 32'd0, 5'd0);
    rd("mtvec_rc0", 4'd1, 12'h305, 32'h0000_2000);
    wrc("mstatus_old", 4'd4, 12'h300, 32'd0, 5'd8, 32'h0000_1800);
    rd("mstatus_mie", 4'd1, 12'h300, 32'h0000_1808);
    wrc("mie_old", 4'd0, 12'h304, 32'hFFFF_FFFF, 5'd0, 32'd0);
    rd("mie_mask", 4'd1, 12'h304, 32'h0000_0880);
    wr(4'd2, 12'h304, 32'h0000_0080, 5'd0);
    rd("mie_rc", 4'd1, 12'h304, 32'h0000_0800);

    // Interrupt with a CSR write in EX; the write must be dropped
    @(negedge clk);
    drive_wr(4'd0, 12'h341, 32'hDEAD_0000, 5'd0);
    ex_pc   = 32'h0000_0140;
    irq_ext = 1'b1;
    #1;
    chk("irq_redirect", {31'd0, trap_redirect}, 32'd1);
    chk("irq_trap_pc", trap_pc, 32'h0000_2000);
    @(posedge clk);
    #1 idle();
    irq_ext = 1'b0;
    @(negedge clk);
    #1 chk("irq_pulse_end", {31'd0, trap_redirect}, 32'd0);
    rd("irq_mepc", 4'd1, 12'h341, 32'h0000_0140);
    rd("irq_mstatus", 4'd1, 12'h300, 32'h0000_1880);

    @(negedge clk);
    ex_valid = 1'b1;
    ex_mret  = 1'b1;
    #1;
    chk("mret_redirect", {31'd0, trap_redirect}, 32'd1);
    chk("mret_trap_pc", trap_pc, 32'h0000_0140);
    @(posedge clk);
    #1 idle();
    rd("mret_mstatus", 4'd1, 12'h300, 32'h0000_1888);

    wr(4'd0, 12'h304, 32'h0000_0080, 5'd0);
    do_wfi(32'h0000_0200);
    repeat (2) @(negedge clk);
    #1 chk("wfi_still_halt", {31'd0, wfi_halt}, 32'd1);
    @(negedge clk);
    irq_timer = 1'b1;
    #1;
    chk("wake_redirect", {31'd0, trap_redirect}, 32'd1);
    chk("wake_trap_pc", trap_pc, 32'h0000_2000);
    @(posedge clk);
    #1 irq_timer = 1'b0;
    @(negedge clk);
    #1 chk("wake_halt_clr", {31'd0, wfi_halt}, 32'd0);
    rd("wake_mepc", 4'd1, 12'h341, 32'h0000_0204);
    rd("wake_mstatus", 4'd1, 12'h300, 32'h0000_1880);

    // MIE now 0: wake resumes after the WFI without a trap
    do_wfi(32'h0000_0300);
    @(negedge clk);
    irq_timer = 1'b1;
    #1;
    chk("wake0_redirect", {31'd0, trap_redirect}, 32'd1);
    chk("wake0_trap_pc", trap_pc, 32'h0000_0304);
    @(posedge clk);
    #1 irq_timer = 1'b0;
    rd("wake0_mepc", 4'd1, 12'h341, 32'h0000_0204);

    irq_ext = 1'b1;
    rd("mip_ext", 4'd1, 12'h344, 32'h0000_0800);
    irq_ext = 1'b0;

    wr(4'd0, 12'hB80, 32'hFFFF_FFFF, 5'd0);
    wr(4'd0, 12'hB00, 32'hFFFF_FFFF, 5'd0);
    rd("wrap_hi_pre", 4'd1, 12'hB80, 32'hFFFF_FFFF);
    rd("wrap_lo", 4'd1, 12'hB00, 32'd0);
    rd("wrap_hi", 4'd8, 12'h000, 32'd0);

    @(negedge clk);
    drive_wr(4'd0, 12'h305, 32'h0000_4000, 5'd0);
    ex_stall = 1'b1;
    @(posedge clk);
    #1 idle();
    rd("stall_mtvec", 4'd1, 12'h305, 32'h0000_2000);

    @(negedge clk);
    wb_retire = 1'b1;
    repeat (3) @(posedge clk);
    #1 wb_retire = 1'b0;
    rd("instret_3", 4'd7, 12'h000, 32'd3);

    do_wfi(32'h0000_0400);
    rstn = 1'b0;
    #1 chk("rst_sleep_halt", {31'd0, wfi_halt}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    rd("rst_mtvec", 4'd1, 12'h305, 32'h0001_0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
